serial_add_ctrl: RTL and testbench

Bit-serial adder controller that time-shares a single `full_adder` cell across a WIDTH-bit addition. Operands are loaded on a start handshake and fed LSB-first through the cell, one bit per clock, with the carry held in a flip-flop between bits. A done pulse follows, and the result stays held. The block sits between a requesting control unit and the one-bit adder datapath, trading latency for area.

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/full_adder.sv | 13 +
 rtl/serial_add_ctrl.sv | 125 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    localparam int unsigned SERIAL_ADD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used as the shared serial datapath.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add (optionally subtract) controller around one full_adder cell.
// Subtraction is built only when SERIAL_ADD_SUB_EN is defined.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = SERIAL_ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               cout_q, cout_d, ovf_q, ovf_d;
    logic [WIDTH-1:0]   load_b;
    logic               load_cin;
    logic               fa_sum, fa_carry;

`ifdef SERIAL_ADD_SUB_EN
    assign load_b   = sub ? ~op_b : op_b;
    assign load_cin = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign load_b     = op_b;
    assign load_cin   = 1'b0;
`endif

    full_adder u_fa (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // Next-state and datapath update; outputs are registered from the *_d values.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = load_b;
                    carry_d = load_cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_carry;
                if (cnt_q == LAST_BIT) begin
                    // carry_q here is the carry into the MSB stage
                    cout_d  = fa_carry;
                    ovf_d   = carry_q ^ fa_carry;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = res_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 with directed vectors.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic         sub;
    logic         busy, done, cout, ovf;
    logic [W-1:0] result;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .sub    (sub),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("cout", 32'(cout), 32'(e.co));
                chk("ovf", 32'(ovf), 32'(e.ov));
            end
        end
    end

    // inj_cyc: RUN cycle in which a stray start is pulsed; rst_cyc: RUN cycle to reset in (0 = never).
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] er, input logic ec, input logic eo,
                          input int inj_cyc, input int rst_cyc);
        int   n;
        logic got;
        exp_t e;
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        sub   = s;
        start = 1'b1;
        if (rst_cyc == 0) begin
            e.res = er; e.co = ec; e.ov = eo;
            sb.push_back(e);
        end
        @(posedge clk);
        n   = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            @(negedge clk);
            n++;
            start = (n == inj_cyc);
            if (start) begin
                op_a = 8'hAA;
                op_b = 8'h55;
            end else begin
                op_a = ~a;
                op_b = ~b;
            end
            if (n == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_result", 32'(result), 32'd0);
                chk("rst_cout", 32'(cout), 32'd0);
                chk("rst_ovf", 32'(ovf), 32'd0);
                start = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                repeat (12) @(negedge clk);
                chk("post_rst_busy", 32'(busy), 32'd0);
                return;
            end
            chk("busy_run", 32'(busy), 32'd1);
            if (done === 1'b1) got = 1'b1;
        end
        chk("latency", 32'(n), 32'(W + 1));
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("held_result", 32'(result), 32'(er));
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        sub   = 1'b0;
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_cout", 32'(cout), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, 0);
        run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0, 0);
`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 0, 0);
`else
        run_op(8'h05, 8'h07, 1'b1, 8'h0C, 1'b0, 1'b0, 0, 0);
`endif
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 3, 0);
        run_op(8'h3C, 8'h0F, 1'b0, 8'h00, 1'b0, 1'b0, 0, 4);
        run_op(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0, 0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
